// File: rtl/stage2_window_gen_pkg.sv
// Shared stage-2 constants for the window generator and its line buffer.
package stage2_window_gen_pkg;

   localparam int KX                 = 5;   // window width
   localparam int KY                 = 5;   // window height
   localparam int ST2_Conv_IBW       = 20;  // stage-2 pixel width
   localparam int ST2_FMAP_W         = 12;  // stage-2 feature-map width
   localparam int ST2_FMAP_H         = 12;  // stage-2 feature-map height
   localparam int ST2_KERNEL_LATENCY = 28;  // cycles the kernel needs per window

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Bits needed to hold values 0..n-1 (at least one bit).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/stage2_line_buffer.sv
// KY-1 chained row buffers. The read address is prefetched one cycle ahead so
// the registered read already holds the column being written when a pixel is
// accepted; each row passes its old value down to the next (older) row.
module stage2_line_buffer
   import stage2_window_gen_pkg::*;
#(
   parameter int DEPTH = ST2_FMAP_W,
   parameter int ROWS  = KY - 1,
   parameter int DW    = ST2_Conv_IBW,
   parameter int AW    = cnt_w(ST2_FMAP_W)
) (
   input  logic               clk,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [AW-1:0]      rd_addr,
   input  logic [DW-1:0]      wr_data,
   output logic [ROWS*DW-1:0] taps      // tap 0 = newest row, tap ROWS-1 = oldest
);

   logic [DW-1:0] rd_data_reg [ROWS];

   genvar gi;
   generate
      for (gi = 0; gi < ROWS; gi++) begin : g_row
         logic [DW-1:0] mem [DEPTH];
         logic [DW-1:0] wr_word;

         if (gi == 0) begin : g_head
            assign wr_word = wr_data;
         end else begin : g_chain
            assign wr_word = rd_data_reg[gi-1];
         end

         // Row storage: write on accept, registered read of the prefetched column.
         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem[wr_addr] <= wr_word;
            end
            rd_data_reg[gi] <= mem[rd_addr];
         end

         assign taps[gi*DW +: DW] = rd_data_reg[gi];
      end
   endgenerate

endmodule

// File: rtl/stage2_window_gen.sv
// Raster-scan KXxKY window generator for stage2_cnn_kernel. Buffers KY-1 rows,
// emits each complete window with a one-cycle valid, and throttles input so
// successive windows are at least GAP cycles apart.
module stage2_window_gen
   import stage2_window_gen_pkg::*;
#(
   parameter int IW  = ST2_FMAP_W,
   parameter int IH  = ST2_FMAP_H,
   parameter int KX  = stage2_window_gen_pkg::KX,
   parameter int KY  = stage2_window_gen_pkg::KY,
   parameter int IBW = ST2_Conv_IBW,
   parameter int GAP = ST2_KERNEL_LATENCY
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_in_valid,
   output logic                  o_in_ready,
   input  logic [IBW-1:0]        i_in_pixel,
   output logic                  o_ot_valid,
   output logic [KX*KY*IBW-1:0]  o_ot_fmap,
   output logic                  o_frame_done
);

   localparam int CW = cnt_w(IW);
   localparam int RW = cnt_w(IH);
   localparam int GW = cnt_w(GAP + 1);
   localparam int FW = KX * KY * IBW;

   state_t            state_reg, state_next;
   logic [CW-1:0]     col_reg, col_next, rd_addr;
   logic [RW-1:0]     row_reg, row_next;
   logic [GW-1:0]     gap_reg, gap_next;
   logic              valid_reg;
   logic [FW-1:0]     fmap_reg;
   logic              win_pos, accept, at_row_end, at_last_row, frame_done;

   // Only columns 1..KX-1 are kept between accepts; column 0 is shifted out
   // on every accept and only ever lives on in the output register.
   logic [KY*(KX-1)*IBW-1:0] win_reg, win_keep;
   logic [FW-1:0]            win_shift;
   logic [IBW-1:0]           new_col [KY];
   logic [(KY-1)*IBW-1:0]    taps;

   assign at_row_end  = (col_reg == CW'(IW - 1));
   assign at_last_row = (row_reg == RW'(IH - 1));
   assign win_pos     = (state_reg == S_RUN) && (col_reg >= CW'(KX - 1));
   assign o_in_ready  = !(win_pos && (gap_reg != '0));
   assign accept      = i_in_valid && o_in_ready;
   assign rd_addr     = reset ? '0 : col_next;

   stage2_line_buffer #(
      .DEPTH (IW),
      .ROWS  (KY - 1),
      .DW    (IBW),
      .AW    (CW)
   ) u_line_buffer (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (col_reg),
      .rd_addr (rd_addr),
      .wr_data (i_in_pixel),
      .taps    (taps)
   );

   genvar gi;
   generate
      // New right column: oldest buffered row at y=0, incoming pixel at y=KY-1.
      for (gi = 0; gi < KY - 1; gi++) begin : g_col
         assign new_col[gi] = taps[(KY-2-gi)*IBW +: IBW];
      end
      assign new_col[KY-1] = i_in_pixel;

      // Window after a one-column left shift.
      for (gi = 0; gi < KY*KX; gi++) begin : g_shift
         localparam int Y = gi / KX;
         localparam int X = gi % KX;
         if (X == KX - 1) begin : g_new
            assign win_shift[gi*IBW +: IBW] = new_col[Y];
         end else begin : g_old
            assign win_shift[gi*IBW +: IBW] = win_reg[(Y*(KX-1)+X)*IBW +: IBW];
         end
      end

      // Columns 1..KX-1 of the shifted window become the stored columns.
      for (gi = 0; gi < KY*(KX-1); gi++) begin : g_keep
         localparam int Y = gi / (KX - 1);
         localparam int X = gi % (KX - 1);
         assign win_keep[gi*IBW +: IBW] = win_shift[(Y*KX+X+1)*IBW +: IBW];
      end
   endgenerate

   // Frame FSM: next state and the frame-done flag.
   always_comb begin
      state_next = state_reg;
      frame_done = 1'b0;
      case (state_reg)
         S_FILL: if (accept && (row_reg == RW'(KY - 2)) && at_row_end) state_next = S_RUN;
         S_RUN:  if (accept && at_last_row && at_row_end) state_next = S_DONE;
         S_DONE: begin
            frame_done = 1'b1;
            state_next = S_FILL;
         end
         default: state_next = S_FILL;
      endcase
   end

   // Raster position counters and window spacing counter.
   always_comb begin
      col_next = col_reg;
      row_next = row_reg;
      gap_next = gap_reg;
      if (accept) begin
         if (at_row_end) begin
            col_next = '0;
            row_next = at_last_row ? '0 : row_reg + 1'b1;
         end else begin
            col_next = col_reg + 1'b1;
         end
      end
      if (accept && win_pos) begin
         gap_next = GW'(GAP - 1);
      end else if (gap_reg != '0) begin
         gap_next = gap_reg - 1'b1;
      end
   end

   // Control state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_FILL;
         col_reg   <= '0;
         row_reg   <= '0;
         gap_reg   <= '0;
         valid_reg <= 1'b0;
         fmap_reg  <= '0;
      end else begin
         state_reg <= state_next;
         col_reg   <= col_next;
         row_reg   <= row_next;
         gap_reg   <= gap_next;
         valid_reg <= accept && win_pos;
         if (accept && win_pos) begin
            fmap_reg <= win_shift;
         end
      end
   end

   // Window columns shift on every accept; contents are don't-care until filled.
   always_ff @(posedge clk) begin
      if (accept) begin
         win_reg <= win_keep;
      end
   end

   assign o_ot_valid   = valid_reg;
   assign o_ot_fmap    = fmap_reg;
   assign o_frame_done = frame_done;

endmodule

// File: tb/tb_stage2_window_gen.sv
// Directed bench for stage2_window_gen: ramps, throttle, bubbles, back-to-back
// frames, mid-frame reset and signed extremes against a golden window model.
module tb_stage2_window_gen;

   localparam int IW  = 12;
   localparam int IH  = 12;
   localparam int KX  = 5;
   localparam int KY  = 5;
   localparam int IBW = 20;
   localparam int GAP = 28;
   localparam int FW  = KX * KY * IBW;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           i_in_valid = 1'b0;
   logic           o_in_ready;
   logic [IBW-1:0] i_in_pixel = '0;
   logic           o_ot_valid;
   logic [FW-1:0]  o_ot_fmap;
   logic           o_frame_done;

   int vectors = 0;
   int miscompares = 0;
   int exp_wins = 0;

   int cyc = 0;
   int mon_wins = 0;
   int mon_done = 0;
   int mon_done_with_valid = 0;
   int last_vcyc = -1;
   int min_gap = 1000000;

   logic [IBW-1:0] img [IH][IW];

   stage2_window_gen #(
      .IW (IW), .IH (IH), .KX (KX), .KY (KY), .IBW (IBW), .GAP (GAP)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_in_valid   (i_in_valid),
      .o_in_ready   (o_in_ready),
      .i_in_pixel   (i_in_pixel),
      .o_ot_valid   (o_ot_valid),
      .o_ot_fmap    (o_ot_fmap),
      .o_frame_done (o_frame_done)
   );

   always #5 clk = ~clk;

   // Output monitor: window count, spacing and frame-done coincidence.
   always @(negedge clk) begin
      if (o_ot_valid) begin
         mon_wins++;
         if (last_vcyc >= 0 && (cyc - last_vcyc) < min_gap) min_gap = cyc - last_vcyc;
         last_vcyc = cyc;
         if (o_frame_done) mon_done_with_valid++;
      end
      if (o_frame_done) mon_done++;
      cyc++;
   end

   task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
      $display("vec %0d %s obs=%0h", vectors, tag, obs[63:0]);
   endtask

   // Golden window whose bottom-right pixel is (r,c).
   function automatic logic [FW-1:0] gold(input int r, input int c);
      logic [FW-1:0] g;
      g = '0;
      for (int y = 0; y < KY; y++)
         for (int x = 0; x < KX; x++)
            g[(y*KX+x)*IBW +: IBW] = img[r-KY+1+y][c-KX+1+x];
      return g;
   endfunction

   // Present one pixel until accepted; returns the number of stalled cycles.
   task automatic push(input logic [IBW-1:0] v, output int n);
      logic rdy;
      i_in_valid = 1'b1;
      i_in_pixel = v;
      n = 0;
      forever begin
         rdy = o_in_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         n++;
         if (n >= 200) begin
            vectors++;
            miscompares++;
            $error("FAIL ready_timeout: stalled %0d cycles, expected acceptance", n);
            break;
         end
      end
      i_in_valid = 1'b0;
   endtask

   task automatic run_frame(input int mode, input int base, input bit bubbles, input int npix);
      logic [IBW-1:0] neg_max;
      logic [IBW-1:0] pos_max;
      int r, c, n;
      neg_max = 20'h80000;
      pos_max = 20'h7FFFF;
      for (int y = 0; y < IH; y++)
         for (int x = 0; x < IW; x++)
            img[y][x] = (mode == 0) ? IBW'(base + y*IW + x) : (((y + x) % 2 != 0) ? pos_max : neg_max);
      for (int p = 0; p < npix; p++) begin
         r = p / IW;
         c = p % IW;
         if (bubbles && $urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
         end
         push(img[r][c], n);
         if (r >= KY-1 && c >= KX-1) begin
            exp_wins++;
            chk("win_valid", FW'(o_ot_valid), FW'(1));
            chk("win_fmap", o_ot_fmap, gold(r, c));
            chk("frame_done", FW'(o_frame_done), FW'(r == IH-1 && c == IW-1));
            if (!bubbles && r == KY-1 && c == KX) chk("stall_first", FW'(n), FW'(GAP-1));
            if (mode == 1 && r == KY-1 && c == KX-1) begin
               chk("msb_neg", FW'(o_ot_fmap[IBW-1]), FW'(1));
               chk("msb_pos", FW'(o_ot_fmap[2*IBW-1]), FW'(0));
            end
         end else begin
            chk("no_valid", FW'(o_ot_valid), FW'(0));
            chk("no_stall", FW'(n), FW'(0));
         end
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_valid", FW'(o_ot_valid), FW'(0));
      chk("rst_fmap", o_ot_fmap, FW'(0));
      chk("rst_done", FW'(o_frame_done), FW'(0));
      chk("rst_ready", FW'(o_in_ready), FW'(1));

      run_frame(0, 0, 1'b0, IW*IH);      // ramp, continuous valid
      run_frame(0, 1000, 1'b0, IW*IH);   // back-to-back frame, +1000
      run_frame(0, 5000, 1'b1, IW*IH);   // random bubbles
      run_frame(0, 0, 1'b0, 70);         // partial frame, then reset

      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("mid_rst_valid", FW'(o_ot_valid), FW'(0));
      chk("mid_rst_fmap", o_ot_fmap, FW'(0));
      chk("mid_rst_done", FW'(o_frame_done), FW'(0));
      chk("mid_rst_ready", FW'(o_in_ready), FW'(1));

      run_frame(0, 0, 1'b0, IW*IH);      // fresh ramp after reset
      run_frame(1, 0, 1'b0, IW*IH);      // signed extremes

      repeat (3) @(posedge clk);
      #1;
      chk("win_total", FW'(mon_wins), FW'(exp_wins));
      chk("done_total", FW'(mon_done), FW'(5));
      chk("done_with_valid", FW'(mon_done_with_valid), FW'(5));
      chk("min_spacing_ok", FW'(min_gap >= GAP), FW'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
